vga_bounce_n: RTL and testbench

Parametrised VGA pattern generator for the 800x600@72 Hz display path (50 MHz pixel clock). It draws N_SQ coloured squares in one horizontal band over a magenta background. Each square moves left or right and reverses on screen edges and on its neighbours. Positions update only at the start of vertical blanking, every MOVE_FRAMES frames, so a frame never shows torn motion. A one-cycle bounce pulse is exported for debug and LED use.

---
 rtl/vga_bounce_n.sv | 113 +++++++++++
 tb/tb_vga_bounce_n.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_bounce_n.sv
// vga_bounce_n: 800x600@72 VGA generator drawing N_SQ bouncing squares on a magenta band background.
module vga_bounce_n #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 56,
    parameter int H_SYNC      = 120,
    parameter int H_TOTAL     = 1040,
    parameter int V_ACTIVE    = 600,
    parameter int V_FP        = 37,
    parameter int V_SYNC      = 6,
    parameter int V_TOTAL     = 666,
    parameter int N_SQ        = 2,
    parameter int SQ_SIZE     = 100,
    parameter int SQ_Y        = 250,
    parameter int STEP        = 1,
    parameter int MOVE_FRAMES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic h_sync,
    output logic v_sync,
    output logic red,
    output logic green,
    output logic blue,
    output logic bounce
);
    localparam int FW = MOVE_FRAMES > 1 ? $clog2(MOVE_FRAMES) : 1;
    localparam logic signed [12:0] HA = 13'(H_ACTIVE);
    localparam logic signed [12:0] SZ = 13'(SQ_SIZE);
    localparam logic signed [12:0] ST = 13'(STEP);
    localparam logic signed [12:0] ST2 = 13'(2 * STEP);
    localparam logic [2:0] PAL [6] = '{3'b011, 3'b110, 3'b010, 3'b100, 3'b001, 3'b111};

    logic [11:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic [FW-1:0] f_q, f_d;
    logic [N_SQ-1:0][11:0] x_q, x_d;
    logic [N_SQ-1:0] dir_q, dir_d, in_x;
    logic hs_q, vs_q, bnc_q, eol, upd, mv, act, band;
    logic [2:0] rgb_q, rgb_d;

    assign eol = h_q == 12'(H_TOTAL - 1);
    assign upd = eol && v_q == 11'(V_ACTIVE - 1);
    assign mv  = upd && f_q == FW'(MOVE_FRAMES - 1);
    assign h_d = eol ? '0 : h_q + 12'd1;
    assign v_d = !eol ? v_q : v_q == 11'(V_TOTAL - 1) ? '0 : v_q + 11'd1;
    assign f_d = !upd ? f_q : mv ? '0 : f_q + FW'(1);

    // Walls need one STEP of room, neighbours two since both may close in together.
    for (genvar i = 0; i < N_SQ; i++) begin : g_sq
        logic signed [12:0] xs, gr, gl, nr, nl;
        logic ok;
        assign xs = $signed({1'b0, x_q[i]});
        if (i == N_SQ - 1) begin : g_wr
            assign gr = HA - (xs + SZ);
            assign nr = ST;
        end else begin : g_nr
            assign gr = $signed({1'b0, x_q[i+1]}) - (xs + SZ);
            assign nr = ST2;
        end
        if (i == 0) begin : g_wl
            assign gl = xs;
            assign nl = ST;
        end else begin : g_nl
            assign gl = xs - ($signed({1'b0, x_q[i-1]}) + SZ);
            assign nl = ST2;
        end
        assign ok       = dir_q[i] ? gr >= nr : gl >= nl;
        assign x_d[i]   = !mv || !ok ? x_q[i] : dir_q[i] ? x_q[i] + 12'(STEP) : x_q[i] - 12'(STEP);
        assign dir_d[i] = dir_q[i] ^ (mv && !ok);
        assign in_x[i]  = h_q >= x_q[i] && 13'(h_q) < 13'(x_q[i]) + 13'(SQ_SIZE);
    end

    assign act  = en && h_q < 12'(H_ACTIVE) && v_q < 11'(V_ACTIVE);
    assign band = v_q >= 11'(SQ_Y) && v_q < 11'(SQ_Y + SQ_SIZE);

    always_comb begin
        rgb_d = 3'b101;
        for (int i = N_SQ - 1; i >= 0; i--) rgb_d = band && in_x[i] ? PAL[i % 6] : rgb_d;
        rgb_d = act ? rgb_d : 3'b000;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q   <= '0;
            v_q   <= '0;
            f_q   <= '0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            rgb_q <= 3'b000;
            bnc_q <= 1'b0;
            for (int i = 0; i < N_SQ; i++) begin
                x_q[i]   <= 12'(i * (H_ACTIVE / N_SQ) + (H_ACTIVE / N_SQ - SQ_SIZE) / 2);
                dir_q[i] <= i % 2 == 0;
            end
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            f_q   <= f_d;
            x_q   <= x_d;
            dir_q <= dir_d;
            hs_q  <= !(h_q >= 12'(H_ACTIVE + H_FP - 1) && h_q < 12'(H_ACTIVE + H_FP + H_SYNC - 1));
            vs_q  <= !(v_q >= 11'(V_ACTIVE + V_FP - 1) && v_q < 11'(V_ACTIVE + V_FP + V_SYNC - 1));
            rgb_q <= rgb_d;
            bnc_q <= mv && dir_d != dir_q;
        end
    end

    assign h_sync = hs_q;
    assign v_sync = vs_q;
    assign {red, green, blue} = rgb_q;
    assign bounce = bnc_q;
endmodule

// File: tb/tb_vga_bounce_n.sv
// tb_vga_bounce_n: checks sync, colour map, en gating and square motion against a frame-level model.
module tb_vga_bounce_n;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_m = 1'b1, rst_s = 1'b1, en_m = 1'b1, en_s = 1'b1;
    logic hs_m, vs_m, r_m, g_m, b_m, bo_m;
    logic [2:0] hs_s, vs_s, r_s, g_s, b_s, bo_s;

    int checks = 0, errors = 0;
    int sn[3]  = '{1, 2, 3};
    int sst[3] = '{2, 1, 1};
    int ssz[3] = '{8, 7, 8};
    int smf[3] = '{1, 1, 3};
    int mx[3][8], md[3][8], mfc[3];
    int obs[3][3][32], first_bo[3], bo_cnt[3];

    vga_bounce_n #(.V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_TOTAL(40), .SQ_Y(10)) u_mid (
        .clk(clk), .rst(rst_m), .en(en_m), .h_sync(hs_m), .v_sync(vs_m),
        .red(r_m), .green(g_m), .blue(b_m), .bounce(bo_m));

    vga_bounce_n #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(4), .H_TOTAL(80), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(1), .V_TOTAL(8), .N_SQ(1), .SQ_SIZE(8), .SQ_Y(0), .STEP(2), .MOVE_FRAMES(1)) u_wall (
        .clk(clk), .rst(rst_s), .en(en_s), .h_sync(hs_s[0]), .v_sync(vs_s[0]),
        .red(r_s[0]), .green(g_s[0]), .blue(b_s[0]), .bounce(bo_s[0]));

    vga_bounce_n #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(4), .H_TOTAL(80), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(1), .V_TOTAL(8), .N_SQ(2), .SQ_SIZE(7), .SQ_Y(0), .STEP(1), .MOVE_FRAMES(1)) u_nb (
        .clk(clk), .rst(rst_s), .en(en_s), .h_sync(hs_s[1]), .v_sync(vs_s[1]),
        .red(r_s[1]), .green(g_s[1]), .blue(b_s[1]), .bounce(bo_s[1]));

    vga_bounce_n #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(4), .H_TOTAL(80), .V_ACTIVE(4), .V_FP(1),
        .V_SYNC(1), .V_TOTAL(8), .N_SQ(3), .SQ_SIZE(8), .SQ_Y(0), .STEP(1), .MOVE_FRAMES(3)) u_mf (
        .clk(clk), .rst(rst_s), .en(en_s), .h_sync(hs_s[2]), .v_sync(vs_s[2]),
        .red(r_s[2]), .green(g_s[2]), .blue(b_s[2]), .bounce(bo_s[2]));

    function automatic logic [2:0] pal(input int i);
        case (i % 6)
            0: return 3'b011;
            1: return 3'b110;
            2: return 3'b010;
            3: return 3'b100;
            4: return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [2:0] colour(input int h, input int v, input logic e, input int ha,
                                          input int va, input int sy, input int sz, input int n,
                                          input int xs[8]);
        if (!e || h >= ha || v >= va) return 3'b000;
        if (v >= sy && v < sy + sz)
            for (int i = 0; i < n; i++)
                if (h >= xs[i] && h < xs[i] + sz) return pal(i);
        return 3'b101;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) begin
                mx[k][i] = (i < sn[k]) ? i * (64 / sn[k]) + (64 / sn[k] - ssz[k]) / 2 : 0;
                md[k][i] = (i % 2 == 0) ? 1 : 0;
            end
            mfc[k] = 0;
        end
    endtask

    // One motion step: every square looks at the old positions, needs STEP of room at a wall
    // and 2*STEP towards a neighbour, otherwise it turns round and stays put.
    task automatic model_step(input int k, output bit ch);
        int nx[8], nd[8];
        int room_r, room_l, need_r, need_l;
        ch = 1'b0;
        for (int i = 0; i < sn[k]; i++) begin
            if (i == sn[k] - 1) begin
                room_r = 64 - (mx[k][i] + ssz[k]);
                need_r = sst[k];
            end else begin
                room_r = mx[k][i+1] - (mx[k][i] + ssz[k]);
                need_r = 2 * sst[k];
            end
            if (i == 0) begin
                room_l = mx[k][i];
                need_l = sst[k];
            end else begin
                room_l = mx[k][i] - (mx[k][i-1] + ssz[k]);
                need_l = 2 * sst[k];
            end
            nx[i] = mx[k][i];
            nd[i] = md[k][i];
            if (md[k][i] != 0) begin
                if (room_r >= need_r) nx[i] = mx[k][i] + sst[k];
                else begin nd[i] = 0; ch = 1'b1; end
            end else begin
                if (room_l >= need_l) nx[i] = mx[k][i] - sst[k];
                else begin nd[i] = 1; ch = 1'b1; end
            end
        end
        for (int i = 0; i < sn[k]; i++) begin
            mx[k][i] = nx[i];
            md[k][i] = nd[i];
        end
    endtask

    task automatic run_small(input int nframes, input bit rec);
        int h, v, f;
        int xr[8];
        bit ch;
        logic [5:0] got, want;
        logic [2:0] er;
        logic be;
        for (int p = 0; p < nframes * 640; p++) begin
            @(posedge clk);
            #1;
            h = p % 80;
            v = (p / 80) % 8;
            f = p / 640;
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 8; i++) xr[i] = mx[k][i];
                er = colour(h, v, en_s, 64, 4, 0, ssz[k], sn[k], xr);
                be = 1'b0;
                if (h == 79 && v == 3) begin
                    if (mfc[k] == smf[k] - 1) begin
                        model_step(k, ch);
                        be = ch;
                        mfc[k] = 0;
                    end else mfc[k]++;
                end
                want = {!(h >= 67 && h < 71), !(v == 4), er, be};
                got = {hs_s[k], vs_s[k], r_s[k], g_s[k], b_s[k], bo_s[k]};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL motion dut=%0d pos=%0d got hs,vs,rgb,bounce=%b want %b", k, p, got, want);
                end
                if (rec && v == 0 && f < 32)
                    for (int j = 0; j < sn[k]; j++)
                        if (got[3:1] == pal(j) && obs[k][j][f] < 0) obs[k][j][f] = h;
                if (rec && bo_s[k]) begin
                    bo_cnt[k]++;
                    if (first_bo[k] < 0) first_bo[k] = f;
                end
            end
            en_s = ((p + 1) / 80) % 8 == 0 || $urandom_range(0, 3) != 0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({hs_m, vs_m, r_m, g_m, b_m, bo_m} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid outputs=%b want 000000", {hs_m, vs_m, r_m, g_m, b_m, bo_m});
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({hs_s[k], vs_s[k], r_s[k], g_s[k], b_s[k], bo_s[k]} !== 6'b0) begin
                errors++;
                $display("FAIL reset_small dut=%0d outputs=%b want 000000", k,
                         {hs_s[k], vs_s[k], r_s[k], g_s[k], b_s[k], bo_s[k]});
            end
        end
    endtask

    task automatic test_video();
        int lp[7] = '{15*1040+150, 15*1040+550, 15*1040, 5*1040+300, 15*1040+820, 12*1040+150, 13*1040+150};
        logic [2:0] lc[7] = '{3'b011, 3'b110, 3'b101, 3'b101, 3'b000, 3'b000, 3'b011};
        int xm[8] = '{150, 550, 0, 0, 0, 0, 0, 0};
        int h, v, start0 = -1, start1 = -1, lowcnt = 0, vs_start = -1, vs_low = 0;
        logic prev_hs = 1'b1;
        logic [5:0] got, want;
        rst_m = 1'b0;
        for (int p = 0; p < 36 * 1040; p++) begin
            @(posedge clk);
            #1;
            h = p % 1040;
            v = (p / 1040) % 40;
            want = {!(h >= 855 && h < 975), !(v >= 32 && v < 34),
                    colour(h, v, en_m, 800, 30, 10, 100, 2, xm), 1'b0};
            got = {hs_m, vs_m, r_m, g_m, b_m, bo_m};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL video pos=%0d got hs,vs,rgb,bounce=%b want %b", p, got, want);
            end
            for (int j = 0; j < 7; j++)
                if (p == lp[j]) begin
                    checks++;
                    if (got[3:1] !== lc[j]) begin
                        errors++;
                        $display("FAIL colour_map pos=%0d rgb=%b want %b", p, got[3:1], lc[j]);
                    end
                end
            if (!hs_m && prev_hs) begin
                if (start0 < 0) start0 = p + 1;
                else if (start1 < 0) start1 = p + 1;
            end
            prev_hs = hs_m;
            if (!hs_m && p < 1040) lowcnt++;
            if (!vs_m) begin
                vs_low++;
                if (vs_start < 0) vs_start = p + 1;
            end
            en_m = (p + 1) / 1040 != 12;
        end
        checks += 5;
        if (start0 != 856) begin errors++; $display("FAIL hsync_first_low clocks=%0d want 856", start0); end
        if (start1 != 1896) begin errors++; $display("FAIL hsync_second_low clocks=%0d want 1896", start1); end
        if (lowcnt != 120) begin errors++; $display("FAIL hsync_width clocks=%0d want 120", lowcnt); end
        if (vs_start != 33281) begin errors++; $display("FAIL vsync_start clocks=%0d want 33281", vs_start); end
        if (vs_low != 2080) begin errors++; $display("FAIL vsync_width clocks=%0d want 2080", vs_low); end
        rst_m = 1'b1;
    endtask

    task automatic test_reset_mid();
        model_reset();
        rst_s = 1'b0;
        run_small(5, 1'b0);
        rst_s = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({hs_s[k], vs_s[k], r_s[k], g_s[k], b_s[k], bo_s[k]} !== 6'b0) begin
                errors++;
                $display("FAIL async_reset dut=%0d outputs=%b want 000000", k,
                         {hs_s[k], vs_s[k], r_s[k], g_s[k], b_s[k], bo_s[k]});
            end
        end
        model_reset();
        en_s = 1'b1;
        @(posedge clk);
        #1;
        rst_s = 1'b0;
    endtask

    task automatic test_motion();
        for (int k = 0; k < 3; k++) begin
            first_bo[k] = -1;
            bo_cnt[k] = 0;
            for (int j = 0; j < 3; j++)
                for (int f = 0; f < 32; f++) obs[k][j][f] = -1;
        end
        run_small(30, 1'b1);
    endtask

    task automatic test_wall_bounce();
        int want[4] = '{28, 56, 56, 54};
        int fr[4] = '{0, 14, 15, 16};
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (obs[0][0][fr[j]] != want[j]) begin
                errors++;
                $display("FAIL wall_x frame=%0d x=%0d want %0d", fr[j], obs[0][0][fr[j]], want[j]);
            end
        end
        checks += 2;
        if (first_bo[0] != 14) begin errors++; $display("FAIL wall_bounce_frame got=%0d want 14", first_bo[0]); end
        if (bo_cnt[0] != 1) begin errors++; $display("FAIL wall_bounce_count got=%0d want 1", bo_cnt[0]); end
    endtask

    task automatic test_neighbour();
        int want[6] = '{12, 44, 24, 32, 23, 33};
        int fr[6] = '{0, 0, 13, 13, 14, 14};
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (obs[1][j % 2][fr[j]] != want[j]) begin
                errors++;
                $display("FAIL nb_x sq=%0d frame=%0d x=%0d want %0d", j % 2, fr[j], obs[1][j % 2][fr[j]], want[j]);
            end
        end
        checks += 2;
        if (first_bo[1] != 12) begin errors++; $display("FAIL nb_bounce_frame got=%0d want 12", first_bo[1]); end
        if (bo_cnt[1] != 1) begin errors++; $display("FAIL nb_bounce_count got=%0d want 1", bo_cnt[1]); end
        for (int f = 0; f < 30; f++) begin
            checks++;
            if (obs[1][0][f] < 0 || obs[1][1][f] < obs[1][0][f] + 7) begin
                errors++;
                $display("FAIL nb_overlap frame=%0d x0=%0d x1=%0d want x1>=x0+7", f, obs[1][0][f], obs[1][1][f]);
            end
        end
    endtask

    task automatic test_move_frames();
        checks += 3;
        if (obs[2][0][2] != 6) begin errors++; $display("FAIL mf_hold x=%0d want 6", obs[2][0][2]); end
        if (obs[2][0][3] != 7) begin errors++; $display("FAIL mf_move x=%0d want 7", obs[2][0][3]); end
        if (first_bo[2] != 20) begin errors++; $display("FAIL mf_bounce_frame got=%0d want 20", first_bo[2]); end
    endtask

    initial begin
        test_reset();
        test_video();
        test_reset_mid();
        test_motion();
        test_wall_bounce();
        test_neighbour();
        test_move_frames();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
